// File: rtl/fir_interp2_pkg.sv
// Shared constants, phase-0 coefficient ROM, FSM state type and Q15 saturation for fir_interp2.
package fir_interp2_pkg;
   localparam int DATA_W    = 16;
   localparam int COEFF_W   = 16;
   localparam int PH_TAPS   = 16;
   localparam int ACC_W     = 37;
   localparam int FRAC_BITS = 15;
   localparam int PROD_W    = DATA_W + COEFF_W;

   typedef logic signed [COEFF_W-1:0] coeff_t;

   // Even taps h[0],h[2],...,h[30]; odd taps are the same ROM read backwards (symmetric prototype).
   localparam coeff_t PH0_COEFF [PH_TAPS] = '{
      -16'sd8,    16'sd24,  -16'sd56,   16'sd112,
      -16'sd200,  16'sd336, -16'sd552,  16'sd960,
       16'sd2560, 16'sd4800, 16'sd7000, 16'sd8224,
       16'sd6400, 16'sd2600, 16'sd600,  -16'sd32
   };

   typedef enum logic [2:0] {IDLE, MAC0, OUT0, MAC1, OUT1} state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   function automatic logic signed [DATA_W-1:0] sat_q15(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)
         return 16'sh7fff;
      else if (v < SAT_MIN)
         return 16'sh8000;
      else
         return v[DATA_W-1:0];
   endfunction
endpackage

// File: rtl/fir_interp2_mac.sv
// Single MAC: accumulates a*b, presents sat((acc_next [+half]) >>> FRAC_BITS) combinationally
// so the final product of a phase can be loaded into the output register on the same edge.
module fir_mac_unit
   import fir_interp2_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      i_clr,
   input  logic                      i_en,
   input  logic signed [DATA_W-1:0]  i_a,
   input  logic signed [COEFF_W-1:0] i_b,
   output logic signed [DATA_W-1:0]  o_sat
);
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_acc_nxt;
   logic signed [ACC_W-1:0]  w_rnd;
   logic signed [ACC_W-1:0]  w_shr;

   assign w_prod     = i_a * i_b;
   assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   assign w_acc_nxt  = i_en ? (r_acc + w_prod_ext) : r_acc;

`ifdef FIR_INTERP2_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2**(FRAC_BITS-1));
   assign w_rnd = w_acc_nxt + RND_HALF;
`else
   assign w_rnd = w_acc_nxt;
`endif

   assign w_shr = w_rnd >>> FRAC_BITS;
   assign o_sat = sat_q15(w_shr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_acc <= '0;
      else if (i_clr)
         r_acc <= '0;
      else if (i_en)
         r_acc <= w_acc_nxt;
   end
endmodule

// File: rtl/fir_interp2.sv
// 2x polyphase interpolating FIR, 16 MAC cycles per output phase, one input per 35 cycles at full rate.
// Define FIR_INTERP2_ROUND_EN for round-half-up before the output shift; saturation is always present.
module fir_interp2
   import fir_interp2_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);
   state_t                    r_state;
   state_t                    w_nxt_state;
   logic [3:0]                r_k;
   logic signed [DATA_W-1:0]  r_taps [PH_TAPS];
   logic signed [DATA_W-1:0]  r_out_data;
   logic                      r_out_valid;
   logic                      w_accept;
   logic                      w_load;
   logic                      w_mac_en;
   logic                      w_mac_clr;
   logic                      w_hs;
   logic signed [COEFF_W-1:0] w_coef;
   logic signed [DATA_W-1:0]  w_sat;

   assign w_hs      = r_out_valid & out_ready;
   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   // Phase 1 reads the ROM in reverse: h[2k+1] = PH0_COEFF[15-k].
   assign w_coef    = (r_state == MAC1) ? PH0_COEFF[~r_k] : PH0_COEFF[r_k];

   always_comb begin
      w_nxt_state = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      w_mac_en    = 1'b0;
      w_mac_clr   = 1'b0;
      case (r_state)
         IDLE: if (in_valid) begin
            w_accept    = 1'b1;
            w_mac_clr   = 1'b1;
            w_nxt_state = MAC0;
         end
         MAC0, MAC1: begin
            w_mac_en = 1'b1;
            if (r_k == 4'(PH_TAPS-1)) begin
               w_load      = 1'b1;
               w_nxt_state = (r_state == MAC0) ? OUT0 : OUT1;
            end
         end
         OUT0: if (w_hs) begin
            w_mac_clr   = 1'b1;
            w_nxt_state = MAC1;
         end
         OUT1: if (w_hs) w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase
      if (clear) begin
         w_nxt_state = IDLE;
         w_accept    = 1'b0;
         w_load      = 1'b0;
         w_mac_en    = 1'b0;
         w_mac_clr   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < PH_TAPS; i++) r_taps[i] <= '0;
      end else begin
         r_state <= w_nxt_state;
         if (clear) begin
            r_k         <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < PH_TAPS; i++) r_taps[i] <= '0;
         end else begin
            if (w_accept) begin
               r_taps[0] <= in_data;
               for (int i = 1; i < PH_TAPS; i++) r_taps[i] <= r_taps[i-1];
            end
            if (w_accept || w_hs)
               r_k <= '0;
            else if (w_mac_en)
               r_k <= r_k + 4'd1;
            if (w_load) begin
               r_out_data  <= w_sat;
               r_out_valid <= 1'b1;
            end else if (w_hs) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

   fir_mac_unit u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_mac_clr),
      .i_en    (w_mac_en),
      .i_a     (r_taps[r_k]),
      .i_b     (w_coef),
      .o_sat   (w_sat)
   );
endmodule
